uart_controller: RTL and testbench

Memory-mapped UART controller between the MIPS CPU data bus and the UART sender/receiver pair. It buffers CPU transmit bytes in a small FIFO and sequences the sender one byte at a time. It captures received bytes into a holding register, exposes status and control in a control register, and raises an interrupt line to the CPU.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/uart_controller.sv | 139 +++++++++++++
 tb/tb_uart_controller.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared register map, CON bit positions and TX sequencer states for the UART controller.
package uart_pkg;

  localparam logic [1:0] REG_TXD = 2'd0;
  localparam logic [1:0] REG_RXD = 2'd1;
  localparam logic [1:0] REG_CON = 2'd2;

  localparam int unsigned CON_TX_IRQ_EN   = 0;
  localparam int unsigned CON_RX_IRQ_EN   = 1;
  localparam int unsigned CON_TX_DONE     = 2;
  localparam int unsigned CON_RX_FULL     = 3;
  localparam int unsigned CON_TX_FULL     = 4;
  localparam int unsigned CON_RX_OVERRUN  = 5;
  localparam int unsigned CON_TX_OVERFLOW = 6;
  localparam int unsigned CON_TX_ACTIVE   = 7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous FIFO with first-word fall-through head; push into a full
// FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/uart_controller.sv
// Memory-mapped UART controller: TX FIFO plus start/busy sequencer, RX holding
// register, CON status/control register and a level interrupt.
module uart_controller
  import uart_pkg::*;
#(
  parameter int unsigned TX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        read_en,
  input  logic        write_en,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  tx_state_e  state;
  logic       tx_irq_en, rx_irq_en, tx_done, rx_full, rx_overrun, tx_overflow;
  logic       tx_irq_en_d, rx_irq_en_d, tx_done_d, rx_full_d, rx_overrun_d, tx_overflow_d;
  logic [7:0] rx_buf, rx_buf_d;
  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_dout;
  logic       wr_txd, wr_con, rd_rxd, pop, tx_done_set, overflow_set, tx_active;
  logic [7:0] con_bits;
  logic       unused_wdata;

  assign wr_txd       = write_en && (addr == REG_TXD);
  assign wr_con       = write_en && (addr == REG_CON);
  assign rd_rxd       = read_en  && (addr == REG_RXD);
  assign pop          = (state == IDLE) && !fifo_empty && !tx_busy;
  assign tx_done_set  = (state == WAIT_DONE) && !tx_busy;
  assign overflow_set = wr_txd && fifo_full && !pop;
  assign tx_active    = (state != IDLE) || !fifo_empty;
  assign unused_wdata = ^wdata[31:8];

  uart_tx_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txd),
    .pop   (pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // TX sequencer: pop, one-cycle start, then track the sender's busy window
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'd0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= fifo_dout;
            tx_start <= 1'b1;
            state    <= START;
          end
        end
        START:     state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  // Next values of CON/RX state; hardware sets are applied after W1C so they win
  always_comb begin
    tx_irq_en_d   = tx_irq_en;
    rx_irq_en_d   = rx_irq_en;
    tx_done_d     = tx_done;
    rx_overrun_d  = rx_overrun;
    tx_overflow_d = tx_overflow;
    rx_full_d     = rx_full;
    rx_buf_d      = rx_buf;
    if (wr_con) begin
      tx_irq_en_d = wdata[CON_TX_IRQ_EN];
      rx_irq_en_d = wdata[CON_RX_IRQ_EN];
      if (wdata[CON_TX_DONE])     tx_done_d     = 1'b0;
      if (wdata[CON_RX_OVERRUN])  rx_overrun_d  = 1'b0;
      if (wdata[CON_TX_OVERFLOW]) tx_overflow_d = 1'b0;
    end
    if (tx_done_set)  tx_done_d     = 1'b1;
    if (overflow_set) tx_overflow_d = 1'b1;
    if (rx_valid && (!rx_full || rd_rxd)) begin
      rx_buf_d  = rx_data;
      rx_full_d = 1'b1;
    end else if (rd_rxd) begin
      rx_full_d = 1'b0;
    end
    if (rx_valid && rx_full && !rd_rxd) rx_overrun_d = 1'b1;
  end

  // irq is registered from next values so it tracks the flags without a cycle of lag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_irq_en   <= 1'b0;
      rx_irq_en   <= 1'b0;
      tx_done     <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      rx_full     <= 1'b0;
      rx_buf      <= 8'd0;
      irq         <= 1'b0;
    end else begin
      tx_irq_en   <= tx_irq_en_d;
      rx_irq_en   <= rx_irq_en_d;
      tx_done     <= tx_done_d;
      rx_overrun  <= rx_overrun_d;
      tx_overflow <= tx_overflow_d;
      rx_full     <= rx_full_d;
      rx_buf      <= rx_buf_d;
      irq         <= (tx_irq_en_d && tx_done_d) || (rx_irq_en_d && rx_full_d);
    end
  end

  assign con_bits = {tx_active, tx_overflow, rx_overrun, fifo_full,
                     rx_full, tx_done, rx_irq_en, tx_irq_en};

  always_comb begin
    rdata = 32'd0;
    case (addr)
      REG_RXD: rdata = 32'(rx_buf);
      REG_CON: rdata = 32'(con_bits);
      default: rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_uart_controller.sv
// Directed bench for uart_controller with a behavioural sender (busy 10 cycles,
// starting 2 cycles after tx_start).
module tb_uart_controller;
  import uart_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        irq;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;

  logic        busy_force = 1'b0;
  logic        snd_busy = 1'b0;
  int unsigned snd_dly = 0;
  int unsigned snd_cnt = 0;
  int unsigned start_cnt = 0;
  logic [7:0]  start_q [$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] d;
  int unsigned starts_before;
  bit          ok;

  uart_controller #(.TX_DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .read_en  (read_en),
    .write_en (write_en),
    .wdata    (wdata),
    .rdata    (rdata),
    .irq      (irq),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  always #5 clk = ~clk;

  assign tx_busy = snd_busy | busy_force;

  // Sender model: busy rises 2 cycles after start and stays high 10 cycles
  always @(posedge clk) begin
    if (tx_start) begin
      snd_dly <= 2;
    end else if (snd_dly != 0) begin
      snd_dly <= snd_dly - 1;
      if (snd_dly == 1) begin
        snd_busy <= 1'b1;
        snd_cnt  <= 10;
      end
    end else if (snd_cnt != 0) begin
      snd_cnt <= snd_cnt - 1;
      if (snd_cnt == 1) snd_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_start) begin
      start_cnt++;
      start_q.push_back(tx_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] v);
    @(negedge clk);
    addr = a; wdata = v; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    @(negedge clk);
    addr = a; read_en = 1'b1;
    #1 v = rdata;
    @(negedge clk);
    read_en = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] v);
    addr = a;
    #1 v = rdata;
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx_idle(input int unsigned budget, input string tag);
    logic [31:0] c;
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      peek(REG_CON, c);
      if (!c[CON_TX_ACTIVE] && !tx_busy) done = 1'b1;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    peek(REG_CON, d);   check("rst_con", d, 32'h0);
    peek(REG_RXD, d);   check("rst_rxd", d, 32'h0);
    peek(REG_TXD, d);   check("rst_txd", d, 32'h0);
    peek(2'd3, d);      check("rst_rsvd", d, 32'h0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_txstart", 32'(tx_start), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'h0);

    // Single byte: write-to-start latency and one-cycle start pulse
    bus_write(REG_TXD, 32'h55);
    check("lat_pre", 32'(tx_start), 32'd0);
    @(negedge clk);
    check("lat_start", 32'(tx_start), 32'd1);
    check("lat_data", 32'(tx_data), 32'h55);
    @(negedge clk);
    check("lat_post", 32'(tx_start), 32'd0);
    wait_tx_idle(40, "tmo_single");
    check("single_starts", start_cnt, 32'd1);
    peek(REG_CON, d);   check("single_con", d, 32'h04);
    check("single_irq_off", 32'(irq), 32'd0);
    bus_write(REG_CON, 32'h01);
    check("txirq_on", 32'(irq), 32'd1);
    bus_write(REG_CON, 32'h05);
    check("txirq_w1c", 32'(irq), 32'd0);
    peek(REG_CON, d);   check("txirq_con", d, 32'h01);
    bus_write(REG_CON, 32'h00);

    // Overflow: five back-to-back writes while the sender is held busy
    busy_force = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      addr = REG_TXD; wdata = 32'(i); write_en = 1'b1;
    end
    @(negedge clk);
    write_en = 1'b0;
    peek(REG_CON, d);   check("ovf_con", d, 32'hD0);
    check("ovf_nostart", start_cnt, 32'd1);
    busy_force = 1'b0;
    wait_tx_idle(200, "tmo_burst");
    check("burst_starts", start_cnt, 32'd5);
    for (int i = 1; i <= 4; i++) begin
      if (start_q.size() > i) check("burst_order", 32'(start_q[i]), 32'(i));
      else check("burst_order_missing", 32'(start_q.size()), 32'(i + 1));
    end
    peek(REG_CON, d);   check("burst_con", d, 32'h44);
    bus_write(REG_CON, 32'h40);
    peek(REG_CON, d);   check("ovf_w1c", d, 32'h04);
    bus_write(REG_CON, 32'h04);
    peek(REG_CON, d);   check("done_w1c", d, 32'h00);

    // RX capture and interrupt
    bus_write(REG_CON, 32'h02);
    rx_pulse(8'hA3);
    peek(REG_CON, d);   check("rx_con", d, 32'h0A);
    check("rx_irq", 32'(irq), 32'd1);
    bus_read(REG_RXD, d);
    check("rx_data", d, 32'hA3);
    check("rx_irq_clr", 32'(irq), 32'd0);
    peek(REG_CON, d);   check("rx_con_clr", d, 32'h02);

    // Overrun, then read coincident with a new byte
    rx_pulse(8'h11);
    rx_pulse(8'h22);
    peek(REG_RXD, d);   check("ovr_keep", d, 32'h11);
    peek(REG_CON, d);   check("ovr_con", d, 32'h2A);
    @(negedge clk);
    addr = REG_RXD; read_en = 1'b1; rx_valid = 1'b1; rx_data = 8'h33;
    #1 check("coinc_old", rdata, 32'h11);
    @(negedge clk);
    read_en = 1'b0; rx_valid = 1'b0;
    peek(REG_RXD, d);   check("coinc_new", d, 32'h33);
    peek(REG_CON, d);   check("coinc_con", d, 32'h2A);
    check("coinc_irq", 32'(irq), 32'd1);
    bus_write(REG_CON, 32'h22);
    peek(REG_CON, d);   check("ovr_w1c", d, 32'h0A);
    bus_read(REG_RXD, d);
    bus_write(REG_CON, 32'h00);
    peek(REG_CON, d);   check("rx_idle_con", d, 32'h00);

    // Reset during WAIT_DONE with two bytes queued
    bus_write(REG_CON, 32'h03);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      addr = REG_TXD; wdata = 32'hA1 + 32'(i); write_en = 1'b1;
    end
    @(negedge clk);
    write_en = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (tx_busy) ok = 1'b1;
    end
    check("tmo_rst_busy", 32'(ok), 32'd1);
    @(negedge clk);
    @(negedge clk);
    starts_before = start_cnt;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    peek(REG_CON, d);   check("rst_mid_con", d, 32'h00);
    check("rst_mid_irq", 32'(irq), 32'd0);
    check("rst_mid_txdata", 32'(tx_data), 32'h0);
    check("rst_mid_busy", 32'(tx_busy), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (!tx_busy) ok = 1'b1;
    end
    check("tmo_rst_release", 32'(ok), 32'd1);
    repeat (4) @(negedge clk);
    check("rst_mid_nostart", start_cnt, starts_before);
    peek(REG_CON, d);   check("rst_mid_con_end", d, 32'h00);

    // Hardware set of tx_done beats a same-cycle W1C
    bus_write(REG_TXD, 32'h77);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (tx_busy) ok = 1'b1;
    end
    check("tmo_race_busy", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (!tx_busy) ok = 1'b1;
    end
    check("tmo_race_idle", 32'(ok), 32'd1);
    addr = REG_CON; wdata = 32'h04; write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    peek(REG_CON, d);   check("race_set_wins", d, 32'h04);
    bus_write(REG_CON, 32'h04);
    peek(REG_CON, d);   check("race_w1c", d, 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
